// File: rtl/niosduino_core_nios2_qsys_0_cpu_debug_ocimem_seq.sv
// rtl/niosduino_core_nios2_qsys_0_cpu_debug_ocimem_seq.sv - OCI debug-memory access sequencer
//
// Turns JTAG debug command strobes into single debug-RAM read/write
// accesses and reports the result through MonDReg / monitor_ready /
// monitor_error.
//
// Parameters:
//   ADDR_W         debug-RAM word-address width (1..17)
//   TIMEOUT_CYCLES waitrequest cycles tolerated per access (1..65535)
//
// Optional feature:
//   NIOSDUINO_DEBUG_OCIMEM_TIMEOUT_EN  builds a 16-bit waitrequest counter
//   that abandons a stalled access after TIMEOUT_CYCLES cycles. Without it
//   an access waits indefinitely and the timeout flag is constant 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   jdo[37:0]                  JTAG debug data (address / write data / go bit)
//   take_action_ocimem_a       load address, optionally start a read (jdo[34])
//   take_no_action_ocimem_a    read at the current address
//   take_action_ocimem_b       load write data, start a write
//   mem_address/read/write/writedata, mem_readdata, mem_waitrequest
//                              debug-RAM access port
//   MonDReg                    monitor data register
//   monitor_ready              last command finished
//   monitor_error              overrun or timeout since last accepted command
//   cmd_busy                   an access is in progress

module niosduino_core_nios2_qsys_0_cpu_debug_ocimem_seq #(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mona,  w_mona_nxt;
  logic [31:0]       r_mond,  w_mond_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              w_timeout;
  logic              w_accept;
  logic              w_any_strobe;
  logic              w_multi_strobe;
  logic              w_abandon;

  // jdo carries fields this block does not use (JTAG instruction bits).
  logic w_unused_jdo;
  assign w_unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

`ifdef NIOSDUINO_DEBUG_OCIMEM_TIMEOUT_EN
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic        r_timeout,  w_timeout_nxt;
  assign w_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // More than one strobe in a cycle: all but the highest priority are dropped.
  assign w_multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a) |
                          (take_action_ocimem_a & take_action_ocimem_b) |
                          (take_no_action_ocimem_a & take_action_ocimem_b);

  always_comb begin
    w_state_nxt   = r_state;
    w_mona_nxt    = r_mona;
    w_mond_nxt    = r_mond;
    w_ready_nxt   = r_ready;
    w_overrun_nxt = r_overrun;
    w_accept      = 1'b0;
    w_abandon     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          w_accept   = 1'b1;
          w_mona_nxt = jdo[17 +: ADDR_W];
          if (jdo[34]) begin
            w_state_nxt = S_RD;
          end
        end else if (take_no_action_ocimem_a) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RD;
        end else if (take_action_ocimem_b) begin
          w_accept    = 1'b1;
          w_mond_nxt  = jdo[34:3];
          w_state_nxt = S_WR;
        end
        // Acceptance clears the flags, but a strobe dropped on the same
        // edge immediately re-flags an overrun.
        if (w_accept) begin
          w_ready_nxt   = 1'b0;
          w_overrun_nxt = w_multi_strobe;
        end
      end
      S_RD, S_WR: begin
        if (w_any_strobe) begin
          w_overrun_nxt = 1'b1;
        end
        if (!mem_waitrequest) begin
          if (r_state == S_RD) begin
            w_mond_nxt = mem_readdata;
          end
          w_mona_nxt  = r_mona + 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef NIOSDUINO_DEBUG_OCIMEM_TIMEOUT_EN
        // Counter holds completed wait cycles; this is the last tolerated one.
        else if (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          w_abandon   = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef NIOSDUINO_DEBUG_OCIMEM_TIMEOUT_EN
  always_comb begin
    w_wait_cnt_nxt = 16'd0;
    w_timeout_nxt  = r_timeout;
    if (r_state != S_IDLE && mem_waitrequest && !w_abandon) begin
      w_wait_cnt_nxt = r_wait_cnt + 16'd1;
    end
    if (w_accept) begin
      w_timeout_nxt = 1'b0;
    end else if (w_abandon) begin
      w_timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end
`else
  logic w_unused_abandon;
  assign w_unused_abandon = w_abandon;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mona    <= '0;
      r_mond    <= 32'd0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_mona    <= w_mona_nxt;
      r_mond    <= w_mond_nxt;
      r_ready   <= w_ready_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign mem_address   = r_mona;
  assign mem_read      = (r_state == S_RD);
  assign mem_write     = (r_state == S_WR);
  assign mem_writedata = r_mond;
  assign MonDReg       = r_mond;
  assign monitor_ready = r_ready;
  assign monitor_error = r_overrun | w_timeout;
  assign cmd_busy      = (r_state != S_IDLE);

endmodule

// File: doc/niosduino_core_nios2_qsys_0_cpu_debug_ocimem_seq.md
NIOSDUINO_CORE_NIOS2_QSYS_0_CPU_DEBUG_OCIMEM_SEQ -- requirements
Module: NIOSDuino_Core_nios2_qsys_0_cpu_debug_ocimem_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameter ADDR_W, default 9: debug-memory word-address width, legal range 1..17.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: waitrequest cycles tolerated per access, legal range 1..65535.
REQ-004 Port: clk, input, 1, system clock.
REQ-005 Port: reset, input, 1, synchronous active-high reset.
REQ-006 Port: jdo, input, 38, JTAG debug data from the debug-slave sysclk stage.
REQ-007 Port: take_action_ocimem_a / take_no_action_ocimem_a / take_action_ocimem_b, input, 1 each, single-cycle command strobes.
REQ-008 Port: mem_address, output, ADDR_W, debug-RAM word address.
REQ-009 Port: mem_read / mem_write, output, 1 each, access requests.
REQ-010 Port: mem_writedata, output, 32; mem_readdata, input, 32; mem_waitrequest, input, 1.
REQ-011 Port: MonDReg, output, 32; monitor_ready, output, 1; monitor_error, output, 1; cmd_busy, output, 1.

Function
REQ-012 FSM states SHALL be IDLE, RD, WR. cmd_busy SHALL be 1 in RD or WR.
REQ-013 In IDLE, take_action_ocimem_a SHALL load MonAReg <= jdo[17 +: ADDR_W]; if jdo[34]=1 it SHALL go to RD at the loaded address the next cycle, else stay IDLE.
REQ-014 In IDLE, take_no_action_ocimem_a SHALL go to RD at the current MonAReg.
REQ-015 In IDLE, take_action_ocimem_b SHALL load MonDReg <= jdo[34:3] and go to WR.
REQ-016 Strobe priority within one cycle SHALL be action_a > no_action_a > action_b; lower-priority strobes SHALL be dropped and set the overrun flag.
REQ-017 Any strobe while in RD or WR SHALL be dropped and set the overrun flag.
REQ-018 Accepting a command SHALL clear monitor_ready, overrun and timeout flags in the same edge.
REQ-019 In RD, mem_read=1, mem_address=MonAReg; in WR, mem_write=1, mem_writedata=MonDReg; both 0 in IDLE.
REQ-020 An access SHALL complete on the first cycle with mem_waitrequest=0; a read SHALL capture MonDReg <= mem_readdata on that edge.
REQ-021 On completion: MonAReg <= MonAReg+1 modulo 2^ADDR_W (all-ones wraps to 0), monitor_ready <= 1, return to IDLE.
REQ-022 Minimum latency from strobe to monitor_ready=1 SHALL be 2 cycles (zero waitrequest).
REQ-023 monitor_error SHALL equal overrun OR timeout flag; flags are sticky until the next accepted command.

Reset
REQ-024 Reset SHALL force IDLE, MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, cmd_busy=0, mem_read=0, mem_write=0, wait counter=0.
REQ-025 Reset asserted mid-access SHALL abandon the access with mem_read/mem_write deasserted on the following cycle and no address increment.
REQ-026 Strobes coincident with reset SHALL be ignored.

Configuration
REQ-027 Macro NIOSDUINO_DEBUG_OCIMEM_TIMEOUT_EN defined: a 16-bit counter SHALL count consecutive waitrequest cycles in RD/WR; on reaching TIMEOUT_CYCLES the access SHALL be abandoned, timeout flag set, monitor_ready set, MonDReg and MonAReg unchanged, FSM to IDLE.
REQ-028 Macro undefined: no counter SHALL be built; accesses wait indefinitely; timeout flag constant 0.

Verification
REQ-029 action_a, jdo[34]=1, address field=9'h010, waitrequest=0, readdata=32'hCAFEF00D -> mem_read one cycle at 0x010, MonDReg=32'hCAFEF00D, monitor_ready=1 two cycles after strobe, MonAReg=0x011.
REQ-030 action_b, jdo[34:3]=32'h12345678, MonAReg=9'h1FF, waitrequest=1 for 3 cycles -> mem_write held 4 cycles at 0x1FF with data 0x12345678, then MonAReg=0x000, monitor_ready=1.
REQ-031 no_action_a strobe repeated 4 times after address 0x020 load -> reads at 0x020..0x023 in order, final MonAReg=0x024.
REQ-032 action_b strobe while in RD, then same-cycle action_a and action_b in IDLE -> monitor_error=1 after first, action_a executed, error cleared on its acceptance then re-set by dropped action_b.
REQ-033 With TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> access abandoned after 4 cycles, monitor_error=1, monitor_ready=1, MonAReg unchanged; without macro, access still pending after 1000 cycles.
REQ-034 reset pulsed 2 cycles into a stalled read -> mem_read=0, all outputs at reset values, subsequent read at 0x000 succeeds.
